// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
//   Datapath -> controller : opcode (IR[31:26]), zero (ALU flag), mem_ready
//   Controller -> datapath : register enables, mux selects, memory strobes,
//                            illegal_op pulse, state code, retired count
// slave  : controller view (drives the control signals)
// master : datapath/memory view (drives opcode/zero/mem_ready)
interface multicycle_ctrl_if;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;

    logic        pc_en;
    logic        ir_write;
    logic        mdr_write;
    logic        a_write;
    logic        b_write;
    logic        aluout_write;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        iord;
    logic        mem_to_reg;
    logic        reg_dst;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic [1:0]  pc_source;
    logic        illegal_op;
    logic [3:0]  state;
    logic [31:0] retired;

    modport slave (
        input  opcode, zero, mem_ready,
        output pc_en, ir_write, mdr_write, a_write, b_write, aluout_write,
               reg_write, mem_read, mem_write, iord, mem_to_reg, reg_dst,
               alu_src_a, alu_src_b, alu_op, pc_source, illegal_op,
               state, retired
    );

    modport master (
        output opcode, zero, mem_ready,
        input  pc_en, ir_write, mdr_write, a_write, b_write, aluout_write,
               reg_write, mem_read, mem_write, iord, mem_to_reg, reg_dst,
               alu_src_a, alu_src_b, alu_op, pc_source, illegal_op,
               state, retired
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle MIPS datapath (PC, IR, MDR, A, B, ALUOut,
// register file). Generates all write enables, mux selects and memory
// strobes, stalls on mem_ready, and counts retired instructions.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; forces IDLE and clears the count
//   bus   : multicycle_ctrl_if.slave control bundle
// Outputs are combinational from the state register (plus mem_ready/zero/
// opcode qualifiers), so an async reset drops every strobe immediately.
module multicycle_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02,
    parameter logic [5:0] OP_ADDI  = 6'h08
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_ctrl_if.slave      bus
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EX   = 4'd11,
        S_ADDI_WB   = 4'd12
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] retired_q, retired_d;
    logic        retire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Wraps naturally at 32 bits.
    assign retired_d   = retire ? retired_q + 32'd1 : retired_q;
    assign bus.state   = state_q;
    assign bus.retired = retired_q;

    always_comb begin
        state_d          = state_q;
        retire           = 1'b0;
        bus.pc_en        = 1'b0;
        bus.ir_write     = 1'b0;
        bus.mdr_write    = 1'b0;
        bus.a_write      = 1'b0;
        bus.b_write      = 1'b0;
        bus.aluout_write = 1'b0;
        bus.reg_write    = 1'b0;
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        bus.iord         = 1'b0;
        bus.mem_to_reg   = 1'b0;
        bus.reg_dst      = 1'b0;
        bus.alu_src_a    = 1'b0;
        bus.alu_src_b    = 2'd0;
        bus.alu_op       = 2'd0;
        bus.pc_source    = 2'd0;
        bus.illegal_op   = 1'b0;

        unique case (state_q)
            S_IDLE: state_d = S_FETCH;

            // PC+4 is computed alongside the fetch; PC and IR load together
            // only in the cycle memory actually returns the word.
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'd1;
                bus.ir_write  = bus.mem_ready;
                bus.pc_en     = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end

            // Speculative branch target into ALUOut while operands load.
            S_DECODE: begin
                bus.a_write      = 1'b1;
                bus.b_write      = 1'b1;
                bus.aluout_write = 1'b1;
                bus.alu_src_b    = 2'd3;
                if (bus.opcode == OP_LW || bus.opcode == OP_SW) state_d = S_MEM_ADDR;
                else if (bus.opcode == OP_RTYPE)                state_d = S_EXECUTE;
                else if (bus.opcode == OP_BEQ)                  state_d = S_BRANCH;
                else if (bus.opcode == OP_J)                    state_d = S_JUMP;
                else if (bus.opcode == OP_ADDI)                 state_d = S_ADDI_EX;
                else begin
                    bus.illegal_op = 1'b1;
                    state_d        = S_FETCH;
                end
            end

            S_MEM_ADDR: begin
                bus.alu_src_a    = 1'b1;
                bus.alu_src_b    = 2'd2;
                bus.aluout_write = 1'b1;
                state_d = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end

            S_MEM_READ: begin
                bus.mem_read  = 1'b1;
                bus.iord      = 1'b1;
                bus.mdr_write = bus.mem_ready;
                if (bus.mem_ready) state_d = S_MEM_WB;
            end

            S_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                retire         = 1'b1;
                state_d        = S_FETCH;
            end

            S_MEM_WRITE: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_EXECUTE: begin
                bus.alu_src_a    = 1'b1;
                bus.alu_op       = 2'd2;
                bus.aluout_write = 1'b1;
                state_d          = S_R_WB;
            end

            S_R_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end

            // Compare A-B; PC takes the target held in ALUOut only if equal.
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'd1;
                bus.pc_source = 2'd1;
                bus.pc_en     = bus.zero;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end

            S_JUMP: begin
                bus.pc_source = 2'd2;
                bus.pc_en     = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end

            S_ADDI_EX: begin
                bus.alu_src_a    = 1'b1;
                bus.alu_src_b    = 2'd2;
                bus.aluout_write = 1'b1;
                state_d          = S_ADDI_WB;
            end

            S_ADDI_WB: begin
                bus.reg_write = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end

            // Unused codes 13-15 recover through FETCH.
            default: state_d = S_FETCH;
        endcase
    end

endmodule
